// File: rtl/axi3_intbus_pkg.sv
// Shared encodings and FSM state type for the AXI3-to-intbus bridge.
package axi3_intbus_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_DATA  = 3'd1,
    S_WR_RESP  = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_RD_DATA  = 3'd5
  } state_t;

  // WRAP walks forward like INCR; only FIXED keeps the address in place.
  function automatic logic addr_advances(input logic [1:0] burst);
    return (burst == BURST_INCR) || (burst == BURST_WRAP);
  endfunction

endpackage

// File: rtl/axi3_intbus_arb.sv
// Two-request arbiter: a lone request wins; on a tie the side not served last time wins.
module axi3_intbus_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic req_wr,
  input  logic req_rd,
  input  logic en,
  output logic gnt_wr,
  output logic gnt_rd
);

  logic prio_wr;

  assign gnt_wr = req_wr & (~req_rd | prio_wr);
  assign gnt_rd = req_rd & (~req_wr | ~prio_wr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_wr <= 1'b1;
    end else if (en && gnt_wr) begin
      prio_wr <= 1'b0;
    end else if (en && gnt_rd) begin
      prio_wr <= 1'b1;
    end
  end

endmodule

// File: rtl/axi3_to_intbus_bridge.sv
// AXI3 slave to single-cycle internal register bus, one beat per bus access.
// Optional AXI3_TO_INTBUS_WSTRB_CHECK_EN: partial-strobe beats are dropped and flagged SLVERR.
module axi3_to_intbus_bridge
  import axi3_intbus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 12,
  parameter int RD_LAT     = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [3:0]            awlen,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_WIDTH-1:0]   wid,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [3:0]            arlen,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [ADDR_WIDTH-3:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_wr,
  output logic                  bus_rd,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output state_t                fsm_state
);

  localparam logic [2:0]            LAT_CYC  = 3'(RD_LAT);
  localparam logic [ADDR_WIDTH-3:0] ONE_WORD = {{(ADDR_WIDTH-3){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-3:0] addr_q, addr_nxt;
  logic [3:0]            len_q, beat_q;
  logic [1:0]            burst_q;
  logic [2:0]            lat_q;
  logic                  gnt_wr, gnt_rd, arb_en, beat_ok;
  logic                  unused_bits;

  assign unused_bits = ^{wid, wlast, wstrb, awaddr[1:0], araddr[1:0]};
  assign fsm_state   = state_q;
  assign bid         = id_q;
  assign rid         = id_q;
  assign rresp       = RESP_OKAY;
  assign addr_nxt    = addr_advances(burst_q) ? addr_q + ONE_WORD : addr_q;
  assign arb_en      = (state_q == S_IDLE) && aresetn;

  axi3_intbus_arb u_arb (
    .clk    (aclk),
    .rst_n  (aresetn),
    .req_wr (awvalid),
    .req_rd (arvalid),
    .en     (arb_en),
    .gnt_wr (gnt_wr),
    .gnt_rd (gnt_rd)
  );

`ifdef AXI3_TO_INTBUS_WSTRB_CHECK_EN
  logic err_q;
  assign beat_ok = (wstrb == 4'hF);
  assign bresp   = err_q ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_q <= 1'b0;
    end else if (awready) begin
      err_q <= 1'b0;
    end else if (wready && wvalid && !beat_ok) begin
      err_q <= 1'b1;
    end
  end
`else
  assign beat_ok = 1'b1;
  assign bresp   = RESP_OKAY;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Handshake: a transfer happens on any clock edge where valid and ready are both high;
  // ready/valid driven here are decoded from the registered state only (plus request in IDLE).
  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    arready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    rvalid  = 1'b0;
    bus_rd  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (aresetn && gnt_wr) begin
          awready = 1'b1;
          state_d = S_WR_DATA;
        end else if (aresetn && gnt_rd) begin
          arready = 1'b1;
          state_d = S_RD_ISSUE;
        end
      end
      S_WR_DATA: begin
        wready = 1'b1;
        if (wvalid && (beat_q == len_q)) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        bvalid = 1'b1;
        if (bready) state_d = S_IDLE;
      end
      S_RD_ISSUE: begin
        bus_rd  = 1'b1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_q == LAT_CYC) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        rvalid = 1'b1;
        if (rready) state_d = rlast ? S_IDLE : S_RD_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wr    <= 1'b0;
      rdata     <= '0;
      rlast     <= 1'b0;
    end else begin
      bus_wr <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (awready) begin
            id_q    <= awid;
            addr_q  <= awaddr[ADDR_WIDTH-1:2];
            len_q   <= awlen;
            burst_q <= awburst;
            beat_q  <= '0;
          end else if (arready) begin
            id_q     <= arid;
            addr_q   <= araddr[ADDR_WIDTH-1:2];
            bus_addr <= araddr[ADDR_WIDTH-1:2];
            len_q    <= arlen;
            burst_q  <= arburst;
            beat_q   <= '0;
          end
        end
        S_WR_DATA: begin
          if (wvalid) begin
            // A dropped beat leaves bus_addr/bus_wdata at the previous strobe's values.
            if (beat_ok) begin
              bus_wr    <= 1'b1;
              bus_addr  <= addr_q;
              bus_wdata <= wdata;
            end
            addr_q <= addr_nxt;
            beat_q <= beat_q + 4'd1;
          end
        end
        S_RD_ISSUE: lat_q <= 3'd1;
        S_RD_WAIT: begin
          if (lat_q == LAT_CYC) begin
            rdata <= bus_rdata;
            rlast <= (beat_q == len_q);
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        S_RD_DATA: begin
          if (rready) begin
            rlast <= 1'b0;
            if (!rlast) begin
              addr_q   <= addr_nxt;
              bus_addr <= addr_nxt;
              beat_q   <= beat_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi3_to_intbus_bridge.sv
// Directed bench for axi3_to_intbus_bridge with a scoreboard of expected bus writes, R beats and B responses.
module tb_axi3_to_intbus_bridge;
  import axi3_intbus_pkg::*;

  localparam int IW = 12;
  localparam int LIMIT = 50;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [IW-1:0] awid = '0, wid = '0, arid = '0;
  logic [31:0]   awaddr = '0, araddr = '0, wdata = '0;
  logic [3:0]    awlen = '0, arlen = '0, wstrb = 4'hF;
  logic [1:0]    awburst = '0, arburst = '0;
  logic          awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic          arvalid = 1'b0, rready = 1'b0;
  logic          awready, wready, bvalid, arready, rlast, rvalid, bus_wr, bus_rd;
  logic [IW-1:0] bid, rid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata, bus_wdata, bus_rdata;
  logic [29:0]   bus_addr;
  state_t        fsm_state;

  axi3_to_intbus_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(IW), .RD_LAT(1)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_rdata(bus_rdata),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  logic [61:0] exp_w_q[$];
  logic [44:0] exp_r_q[$];
  logic [13:0] exp_b_q[$];

  // Bench model of the bridge's write context and arbitration priority
  logic          prio_wr_m = 1'b1;
  logic [29:0]   m_waddr;
  logic [1:0]    m_wburst;
  logic [3:0]    m_wlen, m_rlen;

  // Slave model: data = word address ^ A5A5A5A5, valid only one cycle after bus_rd
  logic        sl_vld = 1'b0;
  logic [29:0] sl_addr = '0;
  always @(posedge aclk) begin
    sl_vld  <= bus_rd;
    sl_addr <= bus_addr;
  end
  assign bus_rdata = sl_vld ? ({2'b00, sl_addr} ^ 32'hA5A5A5A5) : 32'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] adv(input logic [29:0] a, input logic [1:0] b);
    return (b == 2'b00) ? a : a + 30'd1;
  endfunction

  // Scoreboard: pop and compare whenever the DUT produces an output event
  always @(negedge aclk) begin
    logic [61:0] ew;
    logic [44:0] er;
    logic [13:0] eb;
    if (bus_wr) begin
      wr_cnt++;
      ew = (exp_w_q.size() > 0) ? exp_w_q.pop_front() : 'x;
      check("bus_wr", {2'b00, bus_addr, bus_wdata}, {2'b00, ew});
    end
    if (bus_rd) rd_cnt++;
    if (rvalid && rready) begin
      er = (exp_r_q.size() > 0) ? exp_r_q.pop_front() : 'x;
      check("r_beat", {rresp, rid, rlast, rdata}, {2'b00, er});
    end
    if (bvalid && bready) begin
      eb = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 'x;
      check("b_resp", {bid, bresp}, eb);
    end
  end

  function automatic logic sig(input int which);
    case (which)
      0:       return awready | arready;
      1:       return wready;
      2:       return bvalid;
      default: return rvalid;
    endcase
  endfunction

  task automatic wait_on(input int which, input string tag);
    int n;
    n = 0;
    @(negedge aclk);
    while (!sig(which) && n < LIMIT) begin
      @(negedge aclk);
      n++;
    end
    check(tag, (n < LIMIT), 1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_axi"}, {awready, wready, bid, bresp, bvalid, arready, rid, rresp, rlast, rvalid}, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_bus"}, {bus_addr, bus_wr, bus_rd}, 0);
    check({tag, "_wdata"}, bus_wdata, 0);
    check({tag, "_state"}, fsm_state, S_IDLE);
  endtask

  // Driver tasks
  task automatic accept(output logic served_wr);
    logic        exp_wr;
    logic [29:0] a;
    exp_wr = awvalid && (!arvalid || prio_wr_m);
    wait_on(0, "accept_wait");
    served_wr = awready;
    check("arb_grant", {awready, arready}, {exp_wr, !exp_wr});
    prio_wr_m = !served_wr;
    if (served_wr) begin
      m_waddr  = awaddr[31:2];
      m_wburst = awburst;
      m_wlen   = awlen;
      exp_b_q.push_back({awid, 2'b00});
    end else begin
      m_rlen = arlen;
      a = araddr[31:2];
      for (int i = 0; i <= int'(arlen); i++) begin
        exp_r_q.push_back({arid, (i == int'(arlen)), {2'b00, a} ^ 32'hA5A5A5A5});
        a = adv(a, arburst);
      end
    end
    @(posedge aclk);
    #1;
    if (served_wr) awvalid = 1'b0;
    else           arvalid = 1'b0;
  endtask

  task automatic start_aw(input logic [IW-1:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
  endtask

  task automatic start_ar(input logic [IW-1:0] id, input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
  endtask

  task automatic w_phase(input logic [31:0] base, input logic early_last, input int nbeats);
    int nb;
    nb = (nbeats < 0) ? int'(m_wlen) + 1 : nbeats;
    for (int i = 0; i < nb; i++) begin
      wdata  = base + 32'(i);
      wlast  = early_last ? (i == 0) : (i == int'(m_wlen));
      wstrb  = 4'hF;
      wid    = 12'hABC;
      wvalid = 1'b1;
      exp_w_q.push_back({m_waddr, wdata});
      wait_on(1, "w_wait");
      @(posedge aclk);
      #1;
      wvalid  = 1'b0;
      wlast   = 1'b0;
      m_waddr = adv(m_waddr, m_wburst);
    end
  endtask

  task automatic b_phase(input int stall);
    wait_on(2, "b_wait");
    for (int k = 0; k < stall; k++) begin
      @(negedge aclk);
      check("b_hold", {bvalid, bid, bresp}, {1'b1, exp_b_q[0]});
    end
    @(posedge aclk);
    #1 bready = 1'b1;
    @(posedge aclk);
    #1 bready = 1'b0;
  endtask

  task automatic r_phase(input int stall);
    int snap;
    for (int i = 0; i <= int'(m_rlen); i++) begin
      wait_on(3, "r_wait");
      if (i == 0 && stall > 0) begin
        snap = rd_cnt;
        for (int k = 0; k < stall; k++) begin
          @(negedge aclk);
          check("r_hold", {rvalid, rid, rlast, rdata}, {1'b1, exp_r_q[0]});
        end
        check("r_stall_no_strobe", rd_cnt, snap);
      end
      @(posedge aclk);
      #1 rready = 1'b1;
      @(posedge aclk);
      #1 rready = 1'b0;
    end
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [31:0] base, input logic early_last, input int bstall);
    logic s;
    int   w0;
    w0 = wr_cnt;
    start_aw(id, addr, len, burst);
    accept(s);
    w_phase(base, early_last, -1);
    b_phase(bstall);
    check("wr_strobe_count", wr_cnt - w0, int'(len) + 1);
    check("wr_queue_drained", exp_w_q.size(), 0);
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input int rstall);
    logic s;
    int   r0;
    r0 = rd_cnt;
    start_ar(id, addr, len, burst);
    accept(s);
    r_phase(rstall);
    check("rd_strobe_count", rd_cnt - r0, int'(len) + 1);
    check("rd_queue_drained", exp_r_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic served;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    reset_checks("reset");
    @(posedge aclk);
    #1 aresetn = 1'b1;

    // Single write, B held off for 3 cycles
    do_write(12'h123, 32'h4000_0000, 4'd0, BURST_INCR, 32'hDEAD_BEEF, 1'b0, 3);
    // INCR burst of 4, data 1..4
    do_write(12'h02A, 32'h4000_0010, 4'd3, BURST_INCR, 32'd1, 1'b0, 0);
    // FIXED burst of 3 with wlast on the first beat
    do_write(12'h0F0, 32'h4000_0020, 4'd2, BURST_FIXED, 32'h100, 1'b1, 0);
    // Word-address wrap at the top of the address space
    do_write(12'h007, 32'hFFFF_FFFC, 4'd1, BURST_INCR, 32'h5555_0000, 1'b0, 0);
    // Read burst of 2, R held off for 5 cycles on beat 1
    do_read(12'h055, 32'h4000_0008, 4'd1, BURST_INCR, 5);
    do_read(12'h066, 32'h4000_0030, 4'd2, BURST_FIXED, 0);

    // Simultaneous AW/AR: service must alternate W,R,W,R
    for (int k = 0; k < 4; k++) begin
      if (!awvalid) start_aw(12'(12'h300 + k), 32'h4000_0200 + 32'(k * 4), 4'd0, BURST_INCR);
      if (!arvalid) start_ar(12'(12'h400 + k), 32'h4000_0300 + 32'(k * 4), 4'd0, BURST_INCR);
      accept(served);
      check("tie_order", served, (k % 2 == 0));
      if (served) begin
        w_phase(32'hC0DE_0000 + 32'(k), 1'b0, -1);
        b_phase(0);
      end else begin
        r_phase(0);
      end
    end
    accept(served);
    w_phase(32'hC0DE_00FF, 1'b0, -1);
    b_phase(0);

    // Reset in the middle of a 4-beat write burst
    start_aw(12'h0AA, 32'h4000_0100, 4'd3, BURST_INCR);
    accept(served);
    w_phase(32'h7700_0000, 1'b0, 2);
    aresetn = 1'b0;
    exp_b_q.delete();
    prio_wr_m = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    reset_checks("mid_reset");
    @(posedge aclk);
    #1 aresetn = 1'b1;

    do_write(12'h0BB, 32'h4000_0040, 4'd0, BURST_INCR, 32'h1234_5678, 1'b0, 0);
    do_read(12'h0CC, 32'h4000_0040, 4'd0, BURST_INCR, 0);

    repeat (3) @(negedge aclk);
    check("final_w_queue", exp_w_q.size(), 0);
    check("final_r_queue", exp_r_q.size(), 0);
    check("final_b_queue", exp_b_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
